// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: a non-stallable write stream buffered in a small FIFO shares one RAM port with display reads.
// Optional statistics (drop_cnt, peak_level, stats_clr) are built when FB_ARB_STATS_EN is defined.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 48,
  parameter int unsigned WF_DEPTH  = 4,
  parameter int unsigned WR_STARVE = 8,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                       clk24,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ovf,
  output logic [$clog2(WF_DEPTH):0]  wr_level,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_ack,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [15:0]                drop_cnt,
  output logic [$clog2(WF_DEPTH):0]  peak_level
`endif
);

  localparam int unsigned PTR_W = $clog2(WF_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_WR, GRANT_RD} grant_t;

  grant_t             grant;
  logic [ADDR_W-1:0]  fifo_addr [WF_DEPTH];
  logic [DATA_W-1:0]  fifo_data [WF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   level_nxt;
  logic [7:0]         streak;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;
  logic [RD_LAT-1:0]  rd_pipe;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(WF_DEPTH));

  always_comb begin
    grant = GRANT_IDLE;
    if (!rst) begin
      if (!fifo_empty && (!rd_req || streak == 8'(WR_STARVE) || fifo_full))
        grant = GRANT_WR;
      else if (rd_req)
        grant = GRANT_RD;
    end
  end

  // A full FIFO always takes the slot, so a push at full normally pairs with a pop.
  assign rd_ack    = (grant == GRANT_RD);
  assign pop       = (grant == GRANT_WR);
  assign push      = wr_en && (!fifo_full || pop);
  assign drop      = wr_en && !push;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(pop);
  assign wr_level  = level;

  always_ff @(posedge clk24) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level  <= level_nxt;
      wr_ovf <= drop;
    end
  end

  always_ff @(posedge clk24) begin
    if (rst || fifo_empty || pop)
      streak <= '0;
    else if (grant == GRANT_RD && streak != 8'(WR_STARVE))
      streak <= streak + 8'd1;
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (grant)
        GRANT_WR: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= fifo_addr[rd_ptr];
          mem_wdata <= fifo_data[rd_ptr];
        end
        GRANT_RD: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= rd_addr;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // rd_pipe[k] marks a read whose RAM data arrives k+1 cycles after its mem_en cycle.
  always_ff @(posedge clk24) begin
    if (rst) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe[0] <= mem_en && !mem_we;
      for (int unsigned i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
      rd_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1])
        rd_data <= mem_rdata;
    end
  end

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk24) begin
    if (rst || stats_clr) begin
      drop_cnt   <= '0;
      peak_level <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (level_nxt > peak_level)
        peak_level <= level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised and directed bench for fb_port_arbiter against a queue-based reference model.
// Statistics ports are connected and checked when FB_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned DATA_W    = 48;
  localparam int unsigned WF_DEPTH  = 4;
  localparam int unsigned WR_STARVE = 8;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned LVL_W     = $clog2(WF_DEPTH) + 1;

  logic              clk24 = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ovf;
  logic [LVL_W-1:0]  wr_level;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef FB_ARB_STATS_EN
  logic              stats_clr = 1'b0;
  logic [15:0]       drop_cnt;
  logic [LVL_W-1:0]  peak_level;
`endif

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WF_DEPTH(WF_DEPTH),
    .WR_STARVE(WR_STARVE), .RD_LAT(RD_LAT)
  ) dut (
    .clk24(clk24), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ovf(wr_ovf), .wr_level(wr_level), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
    , .stats_clr(stats_clr), .drop_cnt(drop_cnt), .peak_level(peak_level)
`endif
  );

  always #5 clk24 = ~clk24;

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return {a, 8'h5A, a};
  endfunction

  // One-cycle-latency RAM whose contents are a fixed function of the address.
  always @(posedge clk24)
    if (mem_en && !mem_we) mem_rdata <= rd_word(mem_addr);

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;
  typedef struct { int unsigned due; logic [ADDR_W-1:0] a; } rd_t;

  ent_t              fifo_q[$];
  rd_t               rd_q[$];
  int unsigned       streak_m = 0;
  int unsigned       cyc = 0;
  bit                m_ack = 0;
  logic              m_en = 0, m_we = 0, m_ovf = 0, m_valid = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
  int unsigned       m_peak = 0, m_drops = 0;
  int unsigned       n_chk = 0, n_bad = 0;
  int unsigned       rd_next = 'h100;
  int unsigned       wr_next = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit   full, nonempty, do_wr, do_rd, pushed;
    ent_t e;
    full     = (fifo_q.size() == WF_DEPTH);
    nonempty = (fifo_q.size() != 0);
    do_wr    = !rst && nonempty && (!rd_req || streak_m >= WR_STARVE || full);
    do_rd    = !rst && !do_wr && rd_req;
    m_ack    = do_rd;
    @(negedge clk24);
    check_val("rd_ack", rd_ack, do_rd);
    @(posedge clk24);
    cyc++;
    if (rst) begin
      fifo_q.delete(); rd_q.delete();
      streak_m = 0; m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_ovf = 0; m_valid = 0; m_rdata = '0; m_peak = 0; m_drops = 0;
    end else begin
      pushed = 0;
      if (do_wr) begin
        e = fifo_q.pop_front();
        m_en = 1; m_we = 1; m_addr = e.a; m_wdata = e.d; streak_m = 0;
      end else if (do_rd) begin
        m_en = 1; m_we = 0; m_addr = rd_addr;
        rd_q.push_back(rd_t'{cyc + RD_LAT + 1, rd_addr});
        if (nonempty && streak_m < WR_STARVE) streak_m++;
      end else begin
        m_en = 0; m_we = 0;
      end
      if (!nonempty) streak_m = 0;
      if (wr_en && fifo_q.size() < WF_DEPTH) begin
        fifo_q.push_back(ent_t'{wr_addr, wr_data});
        pushed = 1;
      end
      m_ovf   = wr_en && !pushed;
      m_valid = 0;
      if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
        m_valid = 1;
        m_rdata = rd_word(rd_q[0].a);
        void'(rd_q.pop_front());
      end
`ifdef FB_ARB_STATS_EN
      if (stats_clr) begin
        m_drops = 0; m_peak = 0;
      end else begin
        if (m_ovf && m_drops < 'hFFFF) m_drops++;
        if (fifo_q.size() > m_peak) m_peak = fifo_q.size();
      end
`endif
    end
    #1;
    check_val("wr_level", wr_level, fifo_q.size());
    check_val("wr_ovf", wr_ovf, m_ovf);
    check_val("mem_en", mem_en, m_en);
    check_val("mem_we", mem_we, m_we);
    check_val("mem_addr", mem_addr, m_addr);
    check_val("mem_wdata", mem_wdata, m_wdata);
    check_val("rd_valid", rd_valid, m_valid);
    check_val("rd_data", rd_data, m_rdata);
`ifdef FB_ARB_STATS_EN
    check_val("drop_cnt", drop_cnt, m_drops);
    check_val("peak_level", peak_level, m_peak);
`endif
  endtask

  // Read requester: holds rd_addr until acknowledged, then optionally issues the next read.
  task automatic next_rd(input bit want);
    if (!rd_req || m_ack) begin
      rd_req = want;
      if (want) begin
        rd_addr = ADDR_W'(rd_next);
        rd_next = (rd_next + 1) & 'hFFFFF;
      end
    end
  endtask

  task automatic set_wr(input bit en);
    wr_en = en;
    if (en) begin
      wr_addr = ADDR_W'(wr_next);
      wr_data = DATA_W'({$urandom(), $urandom()});
      wr_next = (wr_next + 1) & 'hFF;
    end
  endtask

  initial begin
    int unsigned cnt;
    int unsigned pw [4] = '{20, 60, 90, 50};
    int unsigned pr [4] = '{80, 95, 50, 100};

    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(48'hA0 + i);
      cycle();
    end
    wr_en = 1'b0;
    repeat (4) cycle();

    set_wr(1'b1);
    cycle();
    wr_en = 1'b0;
    rd_next = 'h100;
    next_rd(1'b1);
    for (int i = 0; i < 22; i++) begin
      cycle();
      next_rd(rd_next <= 'h10F);
    end
    next_rd(1'b0);
    repeat (4) cycle();

    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      set_wr(i < 6);
      cycle();
      if (wr_ovf) cnt++;
      next_rd(1'b1);
    end
    wr_en = 1'b0;
    check_val("ovf_pulses_at_full", cnt, 0);
    next_rd(1'b0);
    repeat (4) cycle();

    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1);
      next_rd(1'b1);
      cycle();
    end
    wr_en = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rd_req = 1'b0;
    check_val("level_after_rst", wr_level, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (rd_valid) cnt++;
    end
    check_val("stale_rd_valid", cnt, 0);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 400; i++) begin
        set_wr($urandom_range(99) < pw[p]);
        rst = ($urandom_range(299) == 0);
`ifdef FB_ARB_STATS_EN
        stats_clr = ($urandom_range(49) == 0);
`endif
        cycle();
        next_rd($urandom_range(99) < pr[p]);
      end
    end
    wr_en = 1'b0;
    rst = 1'b0;
`ifdef FB_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    next_rd(1'b0);
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
